bp_cacc_io_bridge: RTL
======================

// Module: bp_cacc_io_bridge
// PURPOSE
//  Front-end between the coherent-accelerator I/O port and the accelerator CSR file. Buffers uncached
//  commands in a 2-entry FIFO, decodes the local address, and issues one CSR read/write at a time
//  with a valid/ready handshake. Returns a valid/yumi response echoing the command header; pulses start_o.
// PARAMETERS
//  addr_width_p     20  local CSR address width (io_cmd addr low bits)
//  data_width_p     64  CSR / io data width
//  payload_width_p  16  opaque header payload, echoed unchanged in response
//  num_regs_p        9  decodable registers (0x000..0x200, stride 0x40)
// PORTS
//  clk_i               in   1              clock; all state updates on rising edge
//  reset_n_i           in   1              synchronous, active-low reset
//  io_cmd_v_i          in   1              command valid
//  io_cmd_ready_o      out  1              command FIFO not full
//  io_cmd_msg_type_i   in   4              bp_mem_msg_e (e_mem_msg_uc_rd / e_mem_msg_uc_wr)
//  io_cmd_addr_i       in   addr_width_p   local CSR byte address
//  io_cmd_size_i       in   3              bp_mem_msg_size_e, echoed
//  io_cmd_payload_i    in   payload_width_p echoed
//  io_cmd_data_i       in   data_width_p   write data
//  io_resp_v_o         out  1              response valid
//  io_resp_yumi_i      in   1              response consumed
//  io_resp_msg_type_o / _addr_o / _size_o / _payload_o  out  (as cmd)  echoed header
//  io_resp_data_o      out  data_width_p   read data (0 for writes/errors)
//  csr_w_v_o, csr_r_v_o out 1              CSR write / read request
//  csr_idx_o           out  4              register index = addr[9:6]
//  csr_wdata_o         out  data_width_p   write data
//  csr_ready_i         in   1              CSR request accepted this cycle
//  csr_rdata_v_i       in   1              read data valid
//  csr_rdata_i         in   data_width_p   read data
//  busy_i              in   1              accelerator running (start..done)
//  start_o             out  1              one-cycle start pulse
// BEHAVIOUR
//  Reset (reset_n_i=0 at edge): FIFO emptied, FSM->IDLE; io_resp_v_o, csr_w_v_o, csr_r_v_o, start_o = 0;
//   io_cmd_ready_o = 1 first cycle after release. Reset mid-transaction drops it, no response.
//  FIFO: enqueue on io_cmd_v_i & io_cmd_ready_o; ready = ~full; no enqueue-bypass when full even if
//   dequeuing same cycle. Entries fully registered (header + data).
//  Decode error: addr[5:0]!=0, idx>=num_regs_p, or msg_type not uc_rd/uc_wr.
//  Write drop: write while busy_i=1 (all registers), or write to idx 4 (status, read-only).
//  FSM IDLE: FIFO non-empty -> pop, latch entry; error -> RESP; else ISSUE.
//   ISSUE: csr_w_v_o (uc_wr, not dropped) or csr_r_v_o (uc_rd) held until csr_ready_i;
//    then write -> RESP, read -> WAIT_RD. Dropped write skips CSR, goes directly to RESP.
//   WAIT_RD: on csr_rdata_v_i capture csr_rdata_i -> RESP. csr_rdata_v_i outside WAIT_RD ignored.
//   RESP: io_resp_v_o=1, outputs stable until io_resp_yumi_i -> IDLE.
//  Exactly one CSR transaction outstanding; commands complete in order.
//  start_o: 1 cycle on ISSUE->RESP for a write to idx 3 with data!=0 (not dropped).
//  Latency: write accepted cycle t, csr_ready_i tied 1 -> csr_w_v_o t+2, io_resp_v_o t+3.
//  Response data: read = captured CSR data; write/error = 0. Header echoed bit-exact.
// CONFIGURATION
//  BP_CACC_IO_BRIDGE_ERRCNT_EN defined: 16-bit sat. counter of decode errors + dropped writes,
//   readable at 0x240 (idx 9, served locally, no CSR request), cleared by any write there
//   (the write is never dropped); reset 0.
//  Not defined: no counter; 0x240 is a decode error.
// TESTING
//  Write 0x1000 to 0x000, csr_ready_i=1 -> csr_w_v_o idx 0 data 0x1000 at t+2; resp data 0 at t+3.
//  Read 0x080, csr_rdata 0x8 two cycles after accept -> io_resp_data_o=0x8, header echoed.
//  Write 1 to 0x0C0 busy_i=0 -> one start_o pulse; repeat busy_i=1 -> no CSR write, no pulse, resp.
//  Read 0x044 and msg_type uc_wr to 0x300 -> no CSR request, resp data 0 (ERRCNT_EN: 0x240 reads 2).
//  3 back-to-back cmds, yumi held 0 -> ready_o low after 2 queued + 1 in flight; in-order resps.
//  reset_n_i=0 in WAIT_RD -> no response, FIFO empty, next read completes normally.

Source files
------------

// File: rtl/bp_cacc_io_bridge.sv
// Uncached I/O command front-end for the accelerator CSR file: 2-entry command FIFO, address
// decode, one CSR access at a time. Optional error counter: define BP_CACC_IO_BRIDGE_ERRCNT_EN.
module bp_cacc_io_bridge #(
  parameter int unsigned addr_width_p    = 20,
  parameter int unsigned data_width_p    = 64,
  parameter int unsigned payload_width_p = 16,
  parameter int unsigned num_regs_p      = 9
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       io_cmd_v_i,
  output logic                       io_cmd_ready_o,
  input  logic [3:0]                 io_cmd_msg_type_i,
  input  logic [addr_width_p-1:0]    io_cmd_addr_i,
  input  logic [2:0]                 io_cmd_size_i,
  input  logic [payload_width_p-1:0] io_cmd_payload_i,
  input  logic [data_width_p-1:0]    io_cmd_data_i,
  output logic                       io_resp_v_o,
  input  logic                       io_resp_yumi_i,
  output logic [3:0]                 io_resp_msg_type_o,
  output logic [addr_width_p-1:0]    io_resp_addr_o,
  output logic [2:0]                 io_resp_size_o,
  output logic [payload_width_p-1:0] io_resp_payload_o,
  output logic [data_width_p-1:0]    io_resp_data_o,
  output logic                       csr_w_v_o,
  output logic                       csr_r_v_o,
  output logic [3:0]                 csr_idx_o,
  output logic [data_width_p-1:0]    csr_wdata_o,
  input  logic                       csr_ready_i,
  input  logic                       csr_rdata_v_i,
  input  logic [data_width_p-1:0]    csr_rdata_i,
  input  logic                       busy_i,
  output logic                       start_o
);

  localparam logic [3:0] MsgUcRd   = 4'd2;
  localparam logic [3:0] MsgUcWr   = 4'd3;
  localparam logic [3:0] StartIdx  = 4'd3;
  localparam logic [3:0] StatusIdx = 4'd4;
  localparam logic [4:0] NumRegs   = 5'(num_regs_p);
`ifdef BP_CACC_IO_BRIDGE_ERRCNT_EN
  localparam logic [3:0] CntIdx    = 4'(num_regs_p);
`endif

  typedef struct packed {
    logic [3:0]                 msg_type;
    logic [addr_width_p-1:0]    addr;
    logic [2:0]                 size;
    logic [payload_width_p-1:0] payload;
    logic [data_width_p-1:0]    data;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

  entry_t cmd_entry, head, cur_q;
  entry_t mem_q [2];
  logic   wptr_q, rptr_q;
  logic [1:0] cnt_q;
  logic   full, enq, pop;

  state_e state_q;
  logic [data_width_p-1:0] rdata_q;
  logic   csr_w_v_q, csr_r_v_q, resp_v_q, start_q, start_arm_q;

  logic [3:0] head_idx;
  logic   head_rd, head_wr, head_cnt, head_err, head_drop;

  assign cmd_entry = '{msg_type: io_cmd_msg_type_i, addr: io_cmd_addr_i, size: io_cmd_size_i,
                       payload: io_cmd_payload_i, data: io_cmd_data_i};

  // No bypass: a full FIFO refuses even when the head is leaving this cycle.
  assign full           = (cnt_q == 2'd2);
  assign io_cmd_ready_o = ~full;
  assign enq            = io_cmd_v_i & ~full;
  assign pop            = (state_q == StIdle) && (cnt_q != 2'd0);
  assign head           = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + {1'b0, enq} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= cmd_entry;
  end

  always_comb begin
    head_idx = head.addr[9:6];
    head_rd  = (head.msg_type == MsgUcRd);
    head_wr  = (head.msg_type == MsgUcWr);
`ifdef BP_CACC_IO_BRIDGE_ERRCNT_EN
    head_cnt = (head_idx == CntIdx) && (head.addr[5:0] == 6'd0) && (head_rd || head_wr);
`else
    head_cnt = 1'b0;
`endif
    head_err  = (head.addr[5:0] != 6'd0) || !(head_rd || head_wr) ||
                (({1'b0, head_idx} >= NumRegs) && !head_cnt);
    head_drop = head_wr && !head_err && !head_cnt && (busy_i || (head_idx == StatusIdx));
  end

`ifdef BP_CACC_IO_BRIDGE_ERRCNT_EN
  logic [15:0] errcnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      errcnt_q <= 16'd0;
    end else if (pop) begin
      if (head_err || head_drop) begin
        if (errcnt_q != 16'hffff) errcnt_q <= errcnt_q + 16'd1;
      end else if (head_cnt && head_wr) begin
        errcnt_q <= 16'd0;
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      rdata_q     <= '0;
      csr_w_v_q   <= 1'b0;
      csr_r_v_q   <= 1'b0;
      resp_v_q    <= 1'b0;
      start_q     <= 1'b0;
      start_arm_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cur_q   <= head;
            rdata_q <= '0;
            if (head_err || head_drop) begin
              state_q  <= StResp;
              resp_v_q <= 1'b1;
            end
`ifdef BP_CACC_IO_BRIDGE_ERRCNT_EN
            else if (head_cnt) begin
              state_q  <= StResp;
              resp_v_q <= 1'b1;
              if (head_rd) rdata_q <= data_width_p'(errcnt_q);
            end
`endif
            else begin
              state_q     <= StIssue;
              csr_w_v_q   <= head_wr;
              csr_r_v_q   <= head_rd;
              start_arm_q <= head_wr && (head_idx == StartIdx) && (head.data != '0);
            end
          end
        end
        StIssue: begin
          if (csr_ready_i) begin
            csr_w_v_q <= 1'b0;
            csr_r_v_q <= 1'b0;
            if (csr_w_v_q) begin
              state_q  <= StResp;
              resp_v_q <= 1'b1;
              start_q  <= start_arm_q;
            end else begin
              state_q <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (csr_rdata_v_i) begin
            rdata_q  <= csr_rdata_i;
            state_q  <= StResp;
            resp_v_q <= 1'b1;
          end
        end
        StResp: begin
          if (io_resp_yumi_i) begin
            resp_v_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io_resp_v_o        = resp_v_q;
  assign io_resp_msg_type_o = cur_q.msg_type;
  assign io_resp_addr_o     = cur_q.addr;
  assign io_resp_size_o     = cur_q.size;
  assign io_resp_payload_o  = cur_q.payload;
  assign io_resp_data_o     = rdata_q;
  assign csr_w_v_o          = csr_w_v_q;
  assign csr_r_v_o          = csr_r_v_q;
  assign csr_idx_o          = cur_q.addr[9:6];
  assign csr_wdata_o        = cur_q.data;
  assign start_o            = start_q;

endmodule
